// File: rtl/phase_freq_detector.sv
`default_nettype none
// ============================================================================
// Module      : phase_freq_detector
// Description : Sampled bang-bang phase/frequency detector. Rising edges of
//               the reference clock and the DCO feedback are synchronised to
//               clk and compared. The result is one-cycle UP/DN pulses for the
//               loop controller, the measured edge offset and a lock flag.
// Ports       : clk       - system clock, rising edge
//               reset     - synchronous, active-high reset
//               ref_in    - reference clock (asynchronous to clk)
//               fb_in     - divided DCO feedback (asynchronous to clk)
//               UP        - one-cycle pulse, reference leads
//               DN        - one-cycle pulse, feedback leads
//               phase_err - offset of the last comparison in clk cycles (sat 255)
//               err_valid - one-cycle pulse, phase_err updated this cycle
//               lock      - LOCK_COUNT consecutive comparisons inside deadzone
// Revision    : 1.0 - initial release
// ============================================================================
module phase_freq_detector #(
    parameter int SYNC_STAGES = 2,
    parameter int DEADZONE    = 1,
    parameter int LOCK_COUNT  = 16,
    parameter int TIMEOUT     = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ref_in,
    input  logic       fb_in,
    output logic       UP,
    output logic       DN,
    output logic [7:0] phase_err,
    output logic       err_valid,
    output logic       lock
);

    localparam logic [7:0] c_DEADZONE   = 8'(DEADZONE);
    localparam logic [7:0] c_LOCK_COUNT = 8'(LOCK_COUNT);
    localparam logic [7:0] c_TIMEOUT    = 8'(TIMEOUT);
    localparam logic [7:0] c_ERR_MAX    = 8'hFF;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_FB  = 2'd1,
        WAIT_REF = 2'd2
    } state_t;

    // Synchroniser chains plus one history flop per input
    logic [SYNC_STAGES-1:0] ref_sync_q;
    logic [SYNC_STAGES-1:0] fb_sync_q;
    logic                   ref_hist_q;
    logic                   fb_hist_q;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] lock_cnt_q, lock_cnt_d;
    logic       up_q, up_d;
    logic       dn_q, dn_d;
    logic [7:0] err_q, err_d;
    logic       valid_q, valid_d;
    logic       lock_q, lock_d;

    logic       w_ref_rise;
    logic       w_fb_rise;
    logic [7:0] w_cnt_inc;

    // History flops reset to 0, so an input already high at reset release
    // is reported as a rising edge.
    assign w_ref_rise = ref_sync_q[SYNC_STAGES-1] & ~ref_hist_q;
    assign w_fb_rise  = fb_sync_q[SYNC_STAGES-1]  & ~fb_hist_q;
    assign w_cnt_inc  = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        up_d       = 1'b0;
        dn_d       = 1'b0;
        valid_d    = 1'b0;
        err_d      = err_q;
        lock_cnt_d = lock_cnt_q;

        case (state_q)
            IDLE: begin
                if (w_ref_rise && w_fb_rise) begin
                    // Coincident edges: zero offset, never outside deadzone
                    valid_d = 1'b1;
                    err_d   = 8'd0;
                end else if (w_ref_rise) begin
                    state_d = WAIT_FB;
                    cnt_d   = 8'd1;
                end else if (w_fb_rise) begin
                    state_d = WAIT_REF;
                    cnt_d   = 8'd1;
                end
            end
            WAIT_FB: begin
                cnt_d = w_cnt_inc;
                if (w_fb_rise) begin
                    valid_d = 1'b1;
                    err_d   = cnt_q;
                    up_d    = (cnt_q > c_DEADZONE);
                    if (w_ref_rise) begin
                        // A new reference edge opens the next comparison
                        cnt_d = 8'd1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (w_ref_rise) begin
                    // Feedback missed a whole reference cycle
                    valid_d = 1'b1;
                    up_d    = 1'b1;
                    err_d   = c_ERR_MAX;
                    cnt_d   = 8'd1;
                end else if (cnt_q == c_TIMEOUT) begin
                    valid_d = 1'b1;
                    up_d    = 1'b1;
                    err_d   = c_ERR_MAX;
                    state_d = IDLE;
                end
            end
            WAIT_REF: begin
                cnt_d = w_cnt_inc;
                if (w_ref_rise) begin
                    valid_d = 1'b1;
                    err_d   = cnt_q;
                    dn_d    = (cnt_q > c_DEADZONE);
                    if (w_fb_rise) begin
                        cnt_d = 8'd1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (w_fb_rise) begin
                    valid_d = 1'b1;
                    dn_d    = 1'b1;
                    err_d   = c_ERR_MAX;
                    cnt_d   = 8'd1;
                end else if (cnt_q == c_TIMEOUT) begin
                    valid_d = 1'b1;
                    dn_d    = 1'b1;
                    err_d   = c_ERR_MAX;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase

        // Lock counter advances only on reported events
        if (valid_d) begin
            if (up_d || dn_d) begin
                lock_cnt_d = 8'd0;
            end else if (lock_cnt_q < c_LOCK_COUNT) begin
                lock_cnt_d = lock_cnt_q + 8'd1;
            end
        end
    end

    assign lock_d = (lock_cnt_d == c_LOCK_COUNT);

    always_ff @(posedge clk) begin
        if (reset) begin
            ref_sync_q <= '0;
            fb_sync_q  <= '0;
            ref_hist_q <= 1'b0;
            fb_hist_q  <= 1'b0;
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            lock_cnt_q <= 8'd0;
            up_q       <= 1'b0;
            dn_q       <= 1'b0;
            err_q      <= 8'd0;
            valid_q    <= 1'b0;
            lock_q     <= 1'b0;
        end else begin
            ref_sync_q <= {ref_sync_q[SYNC_STAGES-2:0], ref_in};
            fb_sync_q  <= {fb_sync_q[SYNC_STAGES-2:0], fb_in};
            ref_hist_q <= ref_sync_q[SYNC_STAGES-1];
            fb_hist_q  <= fb_sync_q[SYNC_STAGES-1];
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lock_cnt_q <= lock_cnt_d;
            up_q       <= up_d;
            dn_q       <= dn_d;
            err_q      <= err_d;
            valid_q    <= valid_d;
            lock_q     <= lock_d;
        end
    end

    assign UP        = up_q;
    assign DN        = dn_q;
    assign phase_err = err_q;
    assign err_valid = valid_q;
    assign lock      = lock_q;

endmodule
`default_nettype wire

// File: tb/tb_phase_freq_detector.sv
`default_nettype none
// ============================================================================
// Module      : tb_phase_freq_detector
// Description : Scoreboard bench for phase_freq_detector. Each stimulus step
//               pushes the event it must produce; a monitor pops and compares
//               on every err_valid pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_phase_freq_detector;

    localparam int c_DEADZONE   = 1;
    localparam int c_LOCK_COUNT = 16;
    localparam int c_TIMEOUT    = 255;

    logic       clk = 1'b0;
    logic       reset;
    logic       ref_in;
    logic       fb_in;
    logic       UP;
    logic       DN;
    logic [7:0] phase_err;
    logic       err_valid;
    logic       lock;

    typedef struct {
        logic       up;
        logic       dn;
        logic       lk;
        logic [7:0] err;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    int   lock_model = 0;

    phase_freq_detector #(
        .SYNC_STAGES (2),
        .DEADZONE    (c_DEADZONE),
        .LOCK_COUNT  (c_LOCK_COUNT),
        .TIMEOUT     (c_TIMEOUT)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .ref_in    (ref_in),
        .fb_in     (fb_in),
        .UP        (UP),
        .DN        (DN),
        .phase_err (phase_err),
        .err_valid (err_valid),
        .lock      (lock)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Expected event; the lock model follows the reported-event rule
    task automatic push_evt(input logic up, input logic dn, input logic [7:0] err);
        exp_t e;
        if (up || dn) lock_model = 0;
        else if (lock_model < c_LOCK_COUNT) lock_model++;
        e.up  = up;
        e.dn  = dn;
        e.err = err;
        e.lk  = (lock_model == c_LOCK_COUNT);
        exp_q.push_back(e);
    endtask

    // Rising edge of ref at cycle a, fb at cycle b, each high 10 cycles
    task automatic pair(input int a, input int b);
        int span;
        int off;
        span = ((a > b) ? a : b) + 20;
        off  = (a > b) ? a - b : b - a;
        push_evt((a < b) && (off > c_DEADZONE), (b < a) && (off > c_DEADZONE), 8'(off));
        for (int c = 0; c < span; c++) begin
            ref_in = (c >= a) && (c < a + 10);
            fb_in  = (c >= b) && (c < b + 10);
            tick(1);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_up"},    32'(UP),        0);
        check({tag, "_dn"},    32'(DN),        0);
        check({tag, "_err"},   32'(phase_err), 0);
        check({tag, "_valid"}, 32'(err_valid), 0);
        check({tag, "_lock"},  32'(lock),      0);
    endtask

    // Monitor
    always @(negedge clk) begin
        if (UP || DN) check("pulse_needs_valid", 32'(err_valid), 1);
        if (err_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_event", 32'({UP, DN, phase_err}), 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("ev_up",   32'(UP),        32'(e.up));
                check("ev_dn",   32'(DN),        32'(e.dn));
                check("ev_err",  32'(phase_err), 32'(e.err));
                check("ev_lock", 32'(lock),      32'(e.lk));
            end
        end
    end

    initial begin
        int guard;
        reset  = 1'b1;
        ref_in = 1'b0;
        fb_in  = 1'b0;
        tick(3);
        check_zero("reset");
        reset = 1'b0;
        tick(5);

        // Coincident edges: lock after the 16th in-deadzone comparison
        for (int i = 0; i < 16; i++) pair(0, 0);
        // Ref leads by 5 -> UP, lock drops
        pair(0, 5);
        // Fb leads by 3 -> DN
        pair(3, 0);
        // Offset 1 both ways -> inside deadzone
        pair(0, 1);
        pair(1, 0);
        // Offset 2 -> just outside deadzone
        pair(2, 0);

        // Ref toggling, fb silent: missed-cycle UPs then a timeout UP
        for (int k = 0; k < 4; k++) begin
            if (k > 0) push_evt(1'b1, 1'b0, 8'hFF);
            ref_in = 1'b1;
            tick(10);
            ref_in = 1'b0;
            tick(10);
        end
        push_evt(1'b1, 1'b0, 8'hFF);
        tick(c_TIMEOUT + 20);
        // Back in IDLE: a normal comparison must resolve
        pair(0, 2);

        // Reset while waiting for fb: pending comparison discarded
        ref_in = 1'b1;
        tick(5);
        ref_in = 1'b0;
        tick(3);
        reset = 1'b1;
        tick(1);
        check_zero("midreset");
        tick(1);
        reset = 1'b0;
        lock_model = 0;
        tick(2);
        // Fb now leads ref by 4 -> DN only, proving fb opened WAIT_REF
        pair(4, 0);

        guard = 0;
        while (exp_q.size() != 0 && guard < 1000) begin
            tick(1);
            guard++;
        end
        check("sb_drain", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
